// File: rtl/chenc_pkg.sv
// ---------------------------------------------------------------------------
// chenc_pkg
// Shared helpers for the channel encoder:
//   ptr_width  - width of a channel index / round-robin pointer for n_ch lanes
//   idle_bin   - the all-ones "no winner" code of the binary index output
//   params_ok  - elaboration-time legality check for N_CH / BIN_W
// ---------------------------------------------------------------------------
package chenc_pkg;

    // Width needed to hold a channel index 0..n_ch-1 (n_ch >= 2, so never 0).
    function automatic int ptr_width(input int n_ch);
        return $clog2(n_ch);
    endfunction

    // All ones of bin_w bits. The caller casts the result to its own width.
    function automatic logic [31:0] idle_bin(input int bin_w);
        return (bin_w >= 32) ? '1 : ((32'd1 << bin_w) - 32'd1);
    endfunction

    // The idle code (all ones) and the 1-based index must never collide, so
    // N_CH must leave at least the top code free: 2 <= N_CH <= 2**BIN_W - 2.
    function automatic bit params_ok(input int n_ch, input int bin_w);
        longint max_ch;
        if (bin_w < 2 || bin_w > 31) begin
            return 1'b0;
        end
        max_ch = (longint'(1) << bin_w) - 2;
        return (n_ch >= 2) && (longint'(n_ch) <= max_ch);
    endfunction

endpackage

// File: rtl/chenc_pick.sv
// ---------------------------------------------------------------------------
// chenc_pick
// Purely combinational rotating descending search over the request vector.
// Scans start, start-1, ..., 0, then wraps to N_CH-1, ..., start+1 and reports
// the first set bit.
//   pos   in   N_CH   channel requests
//   start in   PTR_W  first index examined
//   found out  1      at least one request is set
//   w     out  PTR_W  index of the first request found (0 when !found)
// ---------------------------------------------------------------------------
module chenc_pick #(
    parameter int N_CH  = 8,
    parameter int PTR_W = 3
) (
    input  logic [N_CH-1:0]  pos,
    input  logic [PTR_W-1:0] start,
    output logic             found,
    output logic [PTR_W-1:0] w
);

    always_comb begin
        // NOTE: every output gets a default before the loops; without it a
        // path that assigns nothing would infer a latch.
        found = 1'b0;
        w     = '0;
        // First leg: start down to 0.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (!found && pos[i] && (i <= int'(start))) begin
                found = 1'b1;
                w     = PTR_W'(i);
            end
        end
        // Wrapped leg: N_CH-1 down to start+1.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (!found && pos[i] && (i > int'(start))) begin
                found = 1'b1;
                w     = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/channel_encoder_rr.sv
// ---------------------------------------------------------------------------
// channel_encoder_rr
// Registered channel encoder: picks one requesting channel from pos, registers
// it as a one-hot vector and a 1-based binary index, and offers it downstream
// on a valid/ready handshake. The result is held stable while stalled.
//
// Build option:
//   CHENC_RR_EN defined   - round-robin selection with a winner pointer
//   CHENC_RR_EN undefined - fixed MSB-first priority, no pointer register
//
// Ports:
//   clk     in   1      rising-edge clock
//   arst    in   1      asynchronous active-low reset
//   ena     in   1      sample enable
//   pos     in   N_CH   channel requests, bit i is channel i
//   ready   in   1      downstream accepts the current result
//   valid   out  1      one_bit/bin hold a granted channel
//   one_bit out  N_CH   one-hot winner, zero when idle
//   bin     out  BIN_W  winner index + 1, all ones when idle
// ---------------------------------------------------------------------------
module channel_encoder_rr
    import chenc_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int BIN_W = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             ena,
    input  logic [N_CH-1:0]  pos,
    input  logic             ready,
    output logic             valid,
    output logic [N_CH-1:0]  one_bit,
    output logic [BIN_W-1:0] bin
);

    localparam int               PTR_W    = ptr_width(N_CH);
    localparam logic [BIN_W-1:0] IDLE_BIN = BIN_W'(idle_bin(BIN_W));
    localparam logic [PTR_W-1:0] TOP_IDX  = PTR_W'(N_CH - 1);

    if (!params_ok(N_CH, BIN_W)) begin : g_bad_params
        $error("channel_encoder_rr: N_CH=%0d illegal for BIN_W=%0d", N_CH, BIN_W);
    end

    logic             load;
    logic             xfer;
    logic             found;
    logic [PTR_W-1:0] start;
    logic [PTR_W-1:0] w;

    // A new result may be captured when the output slot is empty or is being
    // drained on this same edge, so a stall releases without a bubble.
    assign load = ena && (!valid || ready);
    assign xfer = valid && ready;

`ifdef CHENC_RR_EN
    logic [PTR_W-1:0] ptr;

    // Search begins just below the last winner, wrapping 0 -> N_CH-1.
    assign start = (ptr == '0) ? TOP_IDX : (ptr - PTR_W'(1));

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            ptr <= '0;
        end else if (load && found) begin
            ptr <= w;
        end
    end
`else
    assign start = TOP_IDX;
`endif

    chenc_pick #(
        .N_CH  (N_CH),
        .PTR_W (PTR_W)
    ) u_pick (
        .pos   (pos),
        .start (start),
        .found (found),
        .w     (w)
    );

    always_ff @(posedge clk or negedge arst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!arst) begin
            valid   <= 1'b0;
            one_bit <= '0;
            bin     <= IDLE_BIN;
        end else if (load) begin
            valid <= found;
            if (found) begin
                one_bit <= N_CH'(1) << w;
                bin     <= BIN_W'(w) + BIN_W'(1);
            end else begin
                one_bit <= '0;
                bin     <= IDLE_BIN;
            end
        end else if (xfer) begin
            valid   <= 1'b0;
            one_bit <= '0;
            bin     <= IDLE_BIN;
        end
    end

endmodule
